addr_hazard_unit: RTL and testbench
===================================

Name: addr_hazard_unit

Overview:
- Parametrised register-address pipeline and hazard detector for the pipelined core.
- Carries NRP read-port addresses and one destination address with per-stage write-valid through the E/M/W stages.
- Produces an encoded per-port forwarding select and a load-use stall request.
- Sits beside the datapath and feeds the hazard unit; replaces the fixed two-port, valid-less match-only scheme.

Parameters:
NRP, 3, number of register read ports tracked
AW, 5, register address width in bits

Ports:
clk  input  1  clock
reset  input  1  synchronous active-low reset
StallE  input  1  hold the E-stage registers
StallM  input  1  hold the M-stage registers
StallW  input  1  hold the W-stage registers
FlushE  input  1  clear E-stage valid bits
FlushW  input  1  clear W-stage valid bit
RAD  input  NRP*AW  decode read addresses; port i occupies bits [i*AW +: AW]
RdValidD  input  NRP  read port i is used by the decode instruction
WA3D  input  AW  decode destination address
RegWriteD  input  1  decode instruction writes WA3D
MemToRegD  input  1  decode instruction is a load
RAE  output  NRP*AW  registered E-stage read addresses
FwdSelE  output  2*NRP  per-port forward select, 2 bits per port
StallReqD  output  1  load-use stall request
WA3W  output  AW  writeback destination address
RegWriteW  output  1  writeback write enable
StallCnt  output  16  load-use stall cycle count (macro-dependent)

Behaviour:
- Clock and reset are decided: one clock `clk`; `reset` is synchronous and active-low. On a `clk` edge with `reset`=0, every register clears:
  - all addresses 0, all valid/RegWrite/MemToReg bits 0;
  - therefore RAE=0, WA3W=0, RegWriteW=0, FwdSelE=0, StallReqD=0, StallCnt=0.
- Reset asserted mid-operation discards all in-flight state on that edge.
- E stage registers RAD, RdValidD, WA3D, RegWriteD and MemToRegD:
  - enable = ~StallE;
  - FlushE=1 clears RdValidE, RegWriteE and MemToRegE on the edge;
  - FlushE wins over StallE; addresses may keep stale values.
- M stage registers WA3E and RegWriteE with enable ~StallM.
  - If StallE=1 and StallM=0, M loads a bubble (RegWriteM=0), so the held E instruction is not duplicated.
- W stage registers WA3M and RegWriteM with enable ~StallW.
  - FlushW=1 clears RegWriteW; FlushW wins over StallW.
- Latency: D-to-E 1 cycle, E-to-M 1 cycle, M-to-W 1 cycle.
- FwdSelE port i is combinational from registered state, with M priority over W:
  - 2'b10 (FWD_M) if RdValidE[i] & RegWriteM & (WA3M==RAE_i);
  - else 2'b01 (FWD_W) if RdValidE[i] & RegWriteW & (WA3W==RAE_i);
  - else 2'b00 (FWD_RF). 2'b11 is never produced.
- StallReqD = RegWriteE & MemToRegE & OR over i of (RdValidD[i] & (RAD_i==WA3E)). It is combinational.
- An unused read port (RdValidD/RdValidE=0) never matches, even on an equal address.
- Address equality is full AW-bit compare.

Optional Feature:
- Macro ADDR_HAZARD_STALLCNT_EN.
- Defined: StallCnt is a 16-bit counter incrementing on every clock with StallReqD=1 and reset=1. It saturates at 16'hFFFF and clears on reset.
- Undefined: StallCnt is tied to 16'h0000 and no counter flops exist.

Decomposition:
- Package addr_hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - localparam STALLCNT_W=16.
- One sub-module, addr_stage_reg: a parametrised-width register with synchronous active-low reset, enable, and a flush that clears only the valid bits. It is instantiated for the E, M and W stages.

Test Plan:
- Reset held low 2 cycles with random inputs -> RAE=0, FwdSelE=0, RegWriteW=0, StallReqD=0, StallCnt=0.
- WA3D=5'd3 with RegWriteD=1, then next cycle RAD port0=3 with RdValidD[0]=1 -> one cycle later FwdSelE[1:0]=FWD_M; after one more advance with a non-writing instruction in M, FwdSelE[1:0]=FWD_W.
- Same address 7 valid in both M and W, E port2 reads 7 -> FwdSelE[5:4]=FWD_M (M priority).
- E holds a load (MemToRegE=1, WA3E=9), D port1 reads 9 with RdValidD[1]=1 -> StallReqD=1. Same case with RdValidD[1]=0 -> StallReqD=0.
- StallE=1, StallM=0 for one cycle -> RegWriteM=0 next cycle. FlushE and StallE together -> RegWriteE cleared.
- With ADDR_HAZARD_STALLCNT_EN, hold a load-use stall for 4 cycles -> StallCnt=4. Preload near saturation -> holds 16'hFFFF.

Source files
------------

// File: rtl/addr_hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : addr_hazard_pkg                                                 |
// | Purpose  : Shared types and constants for the address hazard unit.         |
// |            fwd_sel_t encodes where an E-stage operand is taken from.       |
// | Contents : fwd_sel_t, STALLCNT_W, fwd_pick()                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package addr_hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam int STALLCNT_W = 16;

   // The M stage holds the younger result, so it shadows a W-stage hit.
   function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
      fwd_sel_t sel;
      sel = FWD_RF;
      if (hit_m)      sel = FWD_M;
      else if (hit_w) sel = FWD_W;
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/addr_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : addr_stage_reg                                                  |
// | Purpose  : One pipeline stage register. Data and valid bits load when      |
// |            en_i=1; flush_i clears only the valid bits and takes priority   |
// |            over a held (en_i=0) stage. Data is never cleared by flush.     |
// | Ports    : clk, reset (sync, active-low), en_i, flush_i,                   |
// |            data_i/data_o [DW], valid_i/valid_o [VW]                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module addr_stage_reg
   import addr_hazard_pkg::*;
#(
   parameter int DW = 8,
   parameter int VW = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_i,
   input  logic          flush_i,
   input  logic [DW-1:0] data_i,
   input  logic [VW-1:0] valid_i,
   output logic [DW-1:0] data_o,
   output logic [VW-1:0] valid_o
);

   logic [DW-1:0] data_q;
   logic [VW-1:0] valid_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q  <= '0;
         valid_q <= '0;
      end else begin
         if (en_i) data_q <= data_i;
         if (flush_i)   valid_q <= '0;
         else if (en_i) valid_q <= valid_i;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/addr_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : addr_hazard_unit                                                |
// | Purpose  : Carries NRP read addresses and one destination address with     |
// |            write-valid through E/M/W, produces a per-port forwarding       |
// |            select for the E stage and a load-use stall request for D.      |
// | Ports    : clk, reset (sync, active-low)                                   |
// |            StallE/StallM/StallW, FlushE/FlushW  - pipeline control         |
// |            RAD, RdValidD, WA3D, RegWriteD, MemToRegD - decode inputs       |
// |            RAE, FwdSelE, StallReqD, WA3W, RegWriteW, StallCnt - outputs    |
// | Config   : ADDR_HAZARD_STALLCNT_EN - enables the saturating load-use       |
// |            stall counter on StallCnt; otherwise StallCnt is tied to 0.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module addr_hazard_unit
   import addr_hazard_pkg::*;
#(
   parameter int NRP = 3,
   parameter int AW  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  StallE,
   input  logic                  StallM,
   input  logic                  StallW,
   input  logic                  FlushE,
   input  logic                  FlushW,
   input  logic [NRP*AW-1:0]     RAD,
   input  logic [NRP-1:0]        RdValidD,
   input  logic [AW-1:0]         WA3D,
   input  logic                  RegWriteD,
   input  logic                  MemToRegD,
   output logic [NRP*AW-1:0]     RAE,
   output logic [2*NRP-1:0]      FwdSelE,
   output logic                  StallReqD,
   output logic [AW-1:0]         WA3W,
   output logic                  RegWriteW,
   output logic [STALLCNT_W-1:0] StallCnt
);

   localparam int E_DW = NRP*AW + AW;
   localparam int E_VW = NRP + 2;

   logic [NRP*AW-1:0] rae_q;
   logic [AW-1:0]     wa3e_q;
   logic [NRP-1:0]    rdvalide_q;
   logic              regwritee_q;
   logic              memtorege_q;
   logic [AW-1:0]     wa3m_q;
   logic              regwritem_q;
   logic [AW-1:0]     wa3w_q;
   logic              regwritew_q;

   addr_stage_reg #(.DW(E_DW), .VW(E_VW)) u_stage_e (
      .clk     (clk),
      .reset   (reset),
      .en_i    (~StallE),
      .flush_i (FlushE),
      .data_i  ({RAD, WA3D}),
      .valid_i ({RdValidD, RegWriteD, MemToRegD}),
      .data_o  ({rae_q, wa3e_q}),
      .valid_o ({rdvalide_q, regwritee_q, memtorege_q})
   );

   // A held E instruction must not also advance into M, so M takes a bubble.
   addr_stage_reg #(.DW(AW), .VW(1)) u_stage_m (
      .clk     (clk),
      .reset   (reset),
      .en_i    (~StallM),
      .flush_i (1'b0),
      .data_i  (wa3e_q),
      .valid_i (regwritee_q & ~StallE),
      .data_o  (wa3m_q),
      .valid_o (regwritem_q)
   );

   addr_stage_reg #(.DW(AW), .VW(1)) u_stage_w (
      .clk     (clk),
      .reset   (reset),
      .en_i    (~StallW),
      .flush_i (FlushW),
      .data_i  (wa3m_q),
      .valid_i (regwritem_q),
      .data_o  (wa3w_q),
      .valid_o (regwritew_q)
   );

   assign RAE       = rae_q;
   assign WA3W      = wa3w_q;
   assign RegWriteW = regwritew_q;

   generate
      for (genvar gi = 0; gi < NRP; gi++) begin : g_fwd
         logic hit_m;
         logic hit_w;
         assign hit_m = rdvalide_q[gi] & regwritem_q & (wa3m_q == rae_q[gi*AW +: AW]);
         assign hit_w = rdvalide_q[gi] & regwritew_q & (wa3w_q == rae_q[gi*AW +: AW]);
         assign FwdSelE[2*gi +: 2] = fwd_pick(hit_m, hit_w);
      end
   endgenerate

   // A load in E cannot forward its data to a D-stage reader in time.
   logic use_match;
   always_comb begin
      use_match = 1'b0;
      for (int i = 0; i < NRP; i++) begin
         if (RdValidD[i] && (RAD[i*AW +: AW] == wa3e_q)) use_match = 1'b1;
      end
   end

   assign StallReqD = regwritee_q & memtorege_q & use_match;

`ifdef ADDR_HAZARD_STALLCNT_EN
   logic [STALLCNT_W-1:0] stall_cnt_q;
   logic [STALLCNT_W-1:0] stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (StallReqD && (stall_cnt_q != {STALLCNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + STALLCNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign StallCnt = stall_cnt_q;
`else
   assign StallCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addr_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_addr_hazard_unit                                             |
// | Purpose  : Self-checking bench for addr_hazard_unit: reset checks, a       |
// |            directed vector table, randomized traffic against an            |
// |            instruction-level pipeline model, and (with                     |
// |            ADDR_HAZARD_STALLCNT_EN) stall counter sequences.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_addr_hazard_unit;
   import addr_hazard_pkg::*;

   localparam int NRP = 3;
   localparam int AW  = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  reset, StallE, StallM, StallW, FlushE, FlushW;
   logic [NRP*AW-1:0]     RAD;
   logic [NRP-1:0]        RdValidD;
   logic [AW-1:0]         WA3D;
   logic                  RegWriteD, MemToRegD;
   logic [NRP*AW-1:0]     RAE;
   logic [2*NRP-1:0]      FwdSelE;
   logic                  StallReqD;
   logic [AW-1:0]         WA3W;
   logic                  RegWriteW;
   logic [STALLCNT_W-1:0] StallCnt;

   addr_hazard_unit #(.NRP(NRP), .AW(AW)) dut (
      .clk(clk), .reset(reset), .StallE(StallE), .StallM(StallM), .StallW(StallW),
      .FlushE(FlushE), .FlushW(FlushW), .RAD(RAD), .RdValidD(RdValidD), .WA3D(WA3D),
      .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .RAE(RAE), .FwdSelE(FwdSelE),
      .StallReqD(StallReqD), .WA3W(WA3W), .RegWriteW(RegWriteW), .StallCnt(StallCnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction-level reference model ----------------
   typedef struct packed {
      logic [NRP-1:0][AW-1:0] ra;
      logic [NRP-1:0]         rv;
      logic [AW-1:0]          wa;
      logic                   rw;
      logic                   ld;
   } insn_t;

   insn_t m_e, m_m, m_w;
   int    m_cnt;

   function automatic logic [2*NRP-1:0] exp_fwd();
      logic [2*NRP-1:0] f;
      f = '0;
      for (int i = 0; i < NRP; i++) begin
         if (m_e.rv[i] && m_m.rw && m_m.wa == m_e.ra[i])      f[2*i +: 2] = 2'b10;
         else if (m_e.rv[i] && m_w.rw && m_w.wa == m_e.ra[i]) f[2*i +: 2] = 2'b01;
      end
      return f;
   endfunction

   function automatic logic exp_stall();
      logic s;
      s = 1'b0;
      for (int i = 0; i < NRP; i++)
         if (RdValidD[i] && RAD[i*AW +: AW] == m_e.wa) s = 1'b1;
      return s & m_e.rw & m_e.ld;
   endfunction

   task automatic model_edge();
      logic st;
      st = exp_stall();
      if (!reset) begin
         m_e = '0; m_m = '0; m_w = '0; m_cnt = 0;
      end else begin
         if (!StallW) m_w = m_m;
         if (FlushW)  m_w.rw = 1'b0;
         if (!StallM) begin
            m_m    = m_e;
            m_m.rw = m_e.rw & ~StallE;
         end
         if (!StallE) begin
            m_e.ra = RAD; m_e.rv = RdValidD; m_e.wa = WA3D;
            m_e.rw = RegWriteD; m_e.ld = MemToRegD;
         end
         if (FlushE) begin
            m_e.rv = '0; m_e.rw = 1'b0; m_e.ld = 1'b0;
         end
`ifdef ADDR_HAZARD_STALLCNT_EN
         if (st && m_cnt < 65535) m_cnt++;
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_all();
      chk("RAE",       32'(RAE),       32'(m_e.ra));
      chk("FwdSelE",   32'(FwdSelE),   32'(exp_fwd()));
      chk("StallReqD", 32'(StallReqD), 32'(exp_stall()));
      chk("WA3W",      32'(WA3W),      32'(m_w.wa));
      chk("RegWriteW", 32'(RegWriteW), 32'(m_w.rw));
      chk("StallCnt",  32'(StallCnt),  32'(m_cnt));
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a[AW-1] = 1'b1;
      return a;
   endfunction

   task automatic rand_inputs(input logic allow_reset);
      reset     = allow_reset ? ($urandom_range(0, 39) != 0) : 1'b1;
      StallE    = ($urandom_range(0, 4) == 0);
      StallM    = ($urandom_range(0, 4) == 0);
      StallW    = ($urandom_range(0, 4) == 0);
      FlushE    = ($urandom_range(0, 7) == 0);
      FlushW    = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NRP; i++) RAD[i*AW +: AW] = rnd_addr();
      RdValidD  = NRP'($urandom);
      WA3D      = rnd_addr();
      RegWriteD = 1'($urandom);
      MemToRegD = 1'($urandom);
   endtask

   task automatic set_nop();
      StallE = 0; StallM = 0; StallW = 0; FlushE = 0; FlushW = 0;
      RAD = '0; RdValidD = '0; WA3D = '0; RegWriteD = 0; MemToRegD = 0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic        se, sm, fe;
      logic [14:0] rad;
      logic [2:0]  rdv;
      logic [4:0]  wa;
      logic        rw, ld;
      logic [5:0]  fwd;
      logic        stall, rww;
      logic [4:0]  wa3w;
   } vec_t;

   vec_t tv[22];

   initial begin
      //        se sm fe rad       rdv     wa rw ld fwd        st rww wa3w
      tv[0]  = '{0, 0, 0, 15'd0,    3'b000, 3, 1, 0, 6'b000000, 0, 0, 0};
      tv[1]  = '{0, 0, 0, 15'd3,    3'b001, 0, 0, 0, 6'b000000, 0, 0, 0};
      tv[2]  = '{1, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000010, 0, 0, 0};
      tv[3]  = '{0, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000001, 0, 1, 3};
      tv[4]  = '{0, 0, 0, 15'd0,    3'b000, 7, 1, 0, 6'b000000, 0, 0, 0};
      tv[5]  = '{0, 0, 0, 15'd0,    3'b000, 7, 1, 0, 6'b000000, 0, 0, 0};
      tv[6]  = '{0, 0, 0, 15'h1C00, 3'b100, 0, 0, 0, 6'b000000, 0, 0, 0};
      tv[7]  = '{0, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b100000, 0, 1, 7};
      tv[8]  = '{0, 0, 0, 15'd0,    3'b000, 9, 1, 1, 6'b000000, 0, 1, 7};
      tv[9]  = '{1, 0, 0, 15'h120,  3'b010, 0, 0, 0, 6'b000000, 1, 0, 0};
      tv[10] = '{0, 0, 0, 15'h120,  3'b000, 0, 0, 0, 6'b000000, 0, 0, 0};
      tv[11] = '{0, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000000, 0, 0, 9};
      tv[12] = '{0, 0, 0, 15'd0,    3'b000, 5, 1, 0, 6'b000000, 0, 1, 9};
      tv[13] = '{1, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000000, 0, 0, 0};
      tv[14] = '{0, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000000, 0, 0, 0};
      tv[15] = '{0, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000000, 0, 0, 5};
      tv[16] = '{0, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000000, 0, 1, 5};
      tv[17] = '{0, 0, 0, 15'd0,    3'b000, 6, 1, 0, 6'b000000, 0, 0, 0};
      tv[18] = '{1, 1, 1, 15'd0,    3'b000, 0, 0, 0, 6'b000000, 0, 0, 0};
      tv[19] = '{0, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000000, 0, 0, 0};
      tv[20] = '{0, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000000, 0, 0, 0};
      tv[21] = '{0, 0, 0, 15'd0,    3'b000, 0, 0, 0, 6'b000000, 0, 0, 6};

      m_e = '0; m_m = '0; m_w = '0; m_cnt = 0;

      // Reset held low for two cycles while inputs toggle randomly.
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         rand_inputs(1'b0);
         reset = 1'b0;
         tick();
      end
      set_nop();
      #1;
      chk("rst_RAE",       32'(RAE),       32'd0);
      chk("rst_FwdSelE",   32'(FwdSelE),   32'd0);
      chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
      chk("rst_WA3W",      32'(WA3W),      32'd0);
      chk("rst_StallReqD", 32'(StallReqD), 32'd0);
      chk("rst_StallCnt",  32'(StallCnt),  32'd0);

      // Directed table.
      reset = 1'b1;
      for (int k = 0; k < 22; k++) begin
         set_nop();
         StallE = tv[k].se; StallM = tv[k].sm; FlushE = tv[k].fe;
         RAD = tv[k].rad; RdValidD = tv[k].rdv; WA3D = tv[k].wa;
         RegWriteD = tv[k].rw; MemToRegD = tv[k].ld;
         #1;
         chk($sformatf("vec%0d_FwdSelE", k),   32'(FwdSelE),   32'(tv[k].fwd));
         chk($sformatf("vec%0d_StallReqD", k), 32'(StallReqD), 32'(tv[k].stall));
         chk($sformatf("vec%0d_RegWriteW", k), 32'(RegWriteW), 32'(tv[k].rww));
         chk($sformatf("vec%0d_WA3W", k),      32'(WA3W),      32'(tv[k].wa3w));
         tick();
      end

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         rand_inputs(1'b1);
         #1;
         check_all();
         tick();
      end

`ifdef ADDR_HAZARD_STALLCNT_EN
      // Load-use stall held for four cycles.
      set_nop();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      WA3D = 5'd9; RegWriteD = 1'b1; MemToRegD = 1'b1;
      tick();
      set_nop();
      StallE = 1'b1; RAD = 15'h120; RdValidD = 3'b010;
      for (int k = 0; k < 4; k++) tick();
      chk("cnt_after4",   32'(StallCnt),  32'd4);
      chk("cnt_stallreq", 32'(StallReqD), 32'd1);
      // Drive to saturation and beyond.
      for (int k = 0; k < 65531 + 5; k++) tick();
      chk("cnt_saturate", 32'(StallCnt), 32'hFFFF);
      check_all();
      set_nop();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("cnt_cleared", 32'(StallCnt), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
